// File: rtl/sap_microsequencer.sv
// Five-state T-counter microsequencer for the 8-bit accumulator CPU.
// Emits the control word from T-state, opcode and ALU flags.
module sap_microsequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        step_req,
  input  logic [3:0]  opcode,
  input  logic        carry_flag,
  input  logic        zero_flag,
  output logic [15:0] ctrl_word,
  output logic [2:0]  t_state,
  output logic        tick,
  output logic        instr_done,
  output logic        halted
);

  localparam logic [15:0] HLT = 16'h8000;
  localparam logic [15:0] MI  = 16'h4000;
  localparam logic [15:0] RI  = 16'h2000;
  localparam logic [15:0] RO  = 16'h1000;
  localparam logic [15:0] IO  = 16'h0800;
  localparam logic [15:0] II  = 16'h0400;
  localparam logic [15:0] AI  = 16'h0200;
  localparam logic [15:0] AO  = 16'h0100;
  localparam logic [15:0] EO  = 16'h0080;
  localparam logic [15:0] SU  = 16'h0040;
  localparam logic [15:0] BI  = 16'h0020;
  localparam logic [15:0] OI  = 16'h0010;
  localparam logic [15:0] CE  = 16'h0008;
  localparam logic [15:0] CO  = 16'h0004;
  localparam logic [15:0] J   = 16'h0002;
  localparam logic [15:0] FI  = 16'h0001;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } tstate_e;

  tstate_e state_q;
  logic    halted_q;
  logic    adv;
  logic    op_hlt;

  assign adv        = run | step_req;
  assign tick       = adv & ~halted_q;
  assign instr_done = tick & (state_q == T4);
  assign t_state    = state_q;
  assign halted     = halted_q;
  assign op_hlt     = (opcode == 4'hF);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= T0;
      halted_q <= 1'b0;
    end else if (tick) begin
      // HLT freezes the sequencer back at T0 until reset
      if (state_q == T2 && op_hlt) begin
        state_q  <= T0;
        halted_q <= 1'b1;
      end else begin
        unique case (state_q)
          T0:      state_q <= T1;
          T1:      state_q <= T2;
          T2:      state_q <= T3;
          T3:      state_q <= T4;
          T4:      state_q <= T0;
          default: state_q <= T0;
        endcase
      end
    end
  end

  logic [15:0] w2, w3, w4;

  always_comb begin
    w2 = '0;
    w3 = '0;
    w4 = '0;
    unique case (opcode)
      4'h1: begin w2 = IO | MI; w3 = RO | AI; end
      4'h2: begin w2 = IO | MI; w3 = RO | BI; w4 = EO | AI | FI; end
      4'h3: begin w2 = IO | MI; w3 = RO | BI; w4 = EO | AI | SU | FI; end
      4'h4: begin w2 = IO | MI; w3 = AO | RI; end
      4'h5: w2 = IO | AI;
      4'h6: w2 = IO | J;
      4'h7: w2 = carry_flag ? (IO | J) : '0;
      4'h8: w2 = zero_flag ? (IO | J) : '0;
      4'hE: w2 = AO | OI;
      4'hF: w2 = HLT;
      default: ;
    endcase
  end

  always_comb begin
    ctrl_word = '0;
    if (!halted_q) begin
      unique case (state_q)
        T0:      ctrl_word = CO | MI;
        T1:      ctrl_word = RO | II | CE;
        T2:      ctrl_word = w2;
        T3:      ctrl_word = w3;
        T4:      ctrl_word = w4;
        default: ctrl_word = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_microsequencer.sv
// Bench for sap_microsequencer: directed scenarios then random traffic,
// all cycles compared against a table-driven instruction model.
module tb_sap_microsequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        step_req = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic        carry_flag = 1'b0;
  logic        zero_flag = 1'b0;
  logic [15:0] ctrl_word;
  logic [2:0]  t_state;
  logic        tick;
  logic        instr_done;
  logic        halted;

  sap_microsequencer dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .step_req   (step_req),
    .opcode     (opcode),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .ctrl_word  (ctrl_word),
    .t_state    (t_state),
    .tick       (tick),
    .instr_done (instr_done),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails = 0;
  int          m_t = 0;
  bit          m_h = 1'b0;
  logic [15:0] s_cw;
  logic [2:0]  s_t;
  logic        s_tick;
  logic        s_done;
  logic        s_halt;

  function automatic logic [15:0] exp_word(int t, logic [3:0] op,
                                           bit c, bit z, bit h);
    logic [15:0] e2, e3, e4;
    if (h) return 16'h0000;
    if (t == 0) return 16'h4004;
    if (t == 1) return 16'h1408;
    e2 = 16'h0; e3 = 16'h0; e4 = 16'h0;
    case (op)
      4'h1: begin e2 = 16'h4800; e3 = 16'h1200; end
      4'h2: begin e2 = 16'h4800; e3 = 16'h1020; e4 = 16'h0281; end
      4'h3: begin e2 = 16'h4800; e3 = 16'h1020; e4 = 16'h02C1; end
      4'h4: begin e2 = 16'h4800; e3 = 16'h2100; end
      4'h5: e2 = 16'h0A00;
      4'h6: e2 = 16'h0802;
      4'h7: e2 = c ? 16'h0802 : 16'h0000;
      4'h8: e2 = z ? 16'h0802 : 16'h0000;
      4'hE: e2 = 16'h0110;
      4'hF: e2 = 16'h8000;
      default: ;
    endcase
    return (t == 2) ? e2 : (t == 3) ? e3 : e4;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive, compare against model, clock, update model
  task automatic cyc(input bit r, input bit rn, input bit sr,
                     input logic [3:0] op, input bit c, input bit z,
                     input bit do_chk);
    bit et;
    rst = r; run = rn; step_req = sr;
    opcode = op; carry_flag = c; zero_flag = z;
    #1;
    s_cw = ctrl_word; s_t = t_state; s_tick = tick;
    s_done = instr_done; s_halt = halted;
    et = (rn | sr) && !m_h;
    if (do_chk) begin
      chk("ctrl_word", s_cw, exp_word(m_t, op, c, z, m_h));
      chk("t_state", {13'h0, s_t}, m_t[15:0]);
      chk("tick", {15'h0, s_tick}, {15'h0, et});
      chk("instr_done", {15'h0, s_done}, {15'h0, et && m_t == 4});
      chk("halted", {15'h0, s_halt}, {15'h0, m_h});
    end
    @(posedge clk);
    if (r) begin
      m_t = 0; m_h = 1'b0;
    end else if (et) begin
      if (m_t == 2 && op == 4'hF) begin
        m_t = 0; m_h = 1'b1;
      end else begin
        m_t = (m_t + 1) % 5;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 4'h0, 0, 0, 1);
  endtask

  initial begin
    logic [15:0] fetch_seq [6];
    fetch_seq = '{16'h4004, 16'h1408, 16'h4800,
                  16'h1200, 16'h0000, 16'h4004};
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 4'h0, 0, 0, 0);
    cyc(1, 0, 0, 4'h0, 0, 0, 1);

    // Reset and fetch with LDA
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 0, 4'h1, 0, 0, 1);
      chk("lda_seq", s_cw, fetch_seq[i]);
      chk("lda_done", {15'h0, s_done}, {15'h0, i == 4});
    end
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 4'h1, 0, 0, 1);

    // ADD then SUB
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 4'h2, 0, 0, 1);
      if (i == 3) chk("add_t3", s_cw, 16'h1020);
      if (i == 4) chk("add_t4", s_cw, 16'h0281);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 4'h3, 0, 0, 1);
      if (i == 3) chk("sub_t3", s_cw, 16'h1020);
      if (i == 4) chk("sub_t4", s_cw, 16'h02C1);
    end

    // Conditional jumps: JC untaken, JC taken, JZ taken
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 5; i++) begin
        cyc(0, 1, 0, (k == 2) ? 4'h8 : 4'h7, k == 1, k == 2, 1);
        if (i == 2) chk("jmp_t2", s_cw, (k == 0) ? 16'h0000 : 16'h0802);
      end
      chk("jmp_len", {13'h0, t_state}, 16'h0);
    end

    // Step mode
    do_reset();
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 4'h0, 0, 0, 1);
    chk("idle_t", {13'h0, t_state}, 16'h0);
    cyc(0, 0, 1, 4'h0, 0, 0, 1);
    cyc(0, 0, 0, 4'h0, 0, 0, 1);
    cyc(0, 1, 1, 4'h0, 0, 0, 1);
    chk("step_both_tick", {15'h0, s_tick}, 16'h1);
    cyc(0, 0, 0, 4'h0, 0, 0, 1);
    cyc(0, 0, 1, 4'h0, 0, 0, 1);
    cyc(0, 0, 0, 4'h0, 0, 0, 1);
    chk("step_t3", {13'h0, t_state}, 16'h3);

    // Halt
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 4'hF, 0, 0, 1);
      if (i == 2) chk("hlt_t2", s_cw, 16'h8000);
    end
    for (int i = 0; i < 20; i++) begin
      cyc(0, i[0], i[1], 4'($urandom), 0, 0, 1);
      chk("halt_cw", s_cw, 16'h0000);
      chk("halt_flag", {15'h0, s_halt}, 16'h1);
    end
    do_reset();
    cyc(0, 1, 0, 4'h1, 0, 0, 1);
    chk("restart_cw", s_cw, 16'h4004);

    // Reset at T3 of STA
    do_reset();
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 4'h4, 0, 0, 1);
    cyc(1, 1, 0, 4'h4, 0, 0, 1);
    chk("sta_t3", s_cw, 16'h2100);
    cyc(0, 0, 0, 4'h4, 0, 0, 1);
    chk("rst_mid_cw", s_cw, 16'h4004);
    chk("rst_mid_t", {13'h0, s_t}, 16'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) < 3), $urandom_range(0, 1),
          ($urandom_range(0, 9) < 3), 4'($urandom),
          $urandom_range(0, 1), $urandom_range(0, 1), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
